// File: rtl/axil_demo_regs_pkg.sv
// axil_demo_regs_pkg: shared AXI response codes and register-bank geometry.
package axil_demo_regs_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int NUM_REGS = 32;
    localparam int ADDR_LSB = 2;
    localparam int IDX_W    = $clog2(NUM_REGS);
endpackage

// File: rtl/axil_demo_regs_regfile.sv
// axil_demo_regfile: 32x32 register array, byte-strobed write port, combinational read.
module axil_demo_regfile
    import axil_demo_regs_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];
    always_comb begin
        regs_d = regs_q;
        for (int b = 0; b < 4; b++)
            if (we && wstrb[b]) regs_d[widx][8*b +: 8] = wdata[8*b +: 8];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        else regs_q <= regs_d;
    end
    // Reads see the pre-edge contents, so a same-edge write is not visible.
    assign rdata = regs_q[ridx];
endmodule

// File: rtl/axil_demo_regs.sv
// axil_demo_regs: AXI4-Lite slave front end for a 32-entry config register bank.
module axil_demo_regs
    import axil_demo_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);
    logic        awready_q, awready_d, bvalid_q, bvalid_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d, rf_rdata;
    logic        wr_hs, rd_hs;
    logic        unused_ok;
    always_comb begin
        wr_hs     = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
        rd_hs     = arready_q & S_AXI_ARVALID;
        // Accept only when the response slot is free or draining this edge.
        awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~awready_q & (~bvalid_q | S_AXI_BREADY);
        bvalid_d  = wr_hs ? 1'b1 : (S_AXI_BREADY ? 1'b0 : bvalid_q);
        arready_d = S_AXI_ARVALID & ~arready_q & (~rvalid_q | S_AXI_RREADY);
        rvalid_d  = rd_hs ? 1'b1 : (S_AXI_RREADY ? 1'b0 : rvalid_q);
        rdata_d   = rd_hs ? rf_rdata : rdata_q;
    end
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end
    axil_demo_regfile u_regfile (
        .clk   (S_AXI_ACLK),
        .rst   (S_AXI_ARESET),
        .we    (wr_hs),
        .widx  (S_AXI_AWADDR[ADDR_LSB +: IDX_W]),
        .wdata (S_AXI_WDATA),
        .wstrb (S_AXI_WSTRB),
        .ridx  (S_AXI_ARADDR[ADDR_LSB +: IDX_W]),
        .rdata (rf_rdata)
    );
    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};
endmodule

// File: tb/tb_axil_demo_regs.sv
// tb_axil_demo_regs: scoreboard-driven bench for the AXI-Lite register bank.
module tb_axil_demo_regs;
    logic        S_AXI_ACLK = 0, S_AXI_ARESET = 1;
    logic [6:0]  S_AXI_AWADDR = 0, S_AXI_ARADDR = 0;
    logic [2:0]  S_AXI_AWPROT = 0, S_AXI_ARPROT = 0;
    logic        S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0;
    logic        S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
    logic [31:0] S_AXI_WDATA = 0;
    logic [3:0]  S_AXI_WSTRB = 0;
    logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA;

    int vectors = 0, miscompares = 0;
    logic [31:0] model [32];
    logic [31:0] rq [$];
    logic [1:0]  bq [$];

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    axil_demo_regs dut (
        .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESET(S_AXI_ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
        .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [43:0] outs();
        return {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
                S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, 3'b0};
    endfunction

    task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        logic [1:0] exp;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
        bq.push_back(2'b00);
        do begin @(posedge S_AXI_ACLK); #1; n++; end while (!S_AXI_AWREADY && n < 20);
        vectors++;
        exp = bq.pop_front();
        if (!S_AXI_AWREADY) begin
            miscompares++;
            $display("FAIL wr_timeout addr=%h: AWREADY=%b after %0d cycles, required 1", a, S_AXI_AWREADY, n);
            S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        end else begin
            @(posedge S_AXI_ACLK); #1;
            S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
            model[a[6:2]] = merge(model[a[6:2]], d, s);
            if ({S_AXI_BVALID, S_AXI_BRESP} !== {1'b1, exp}) begin
                miscompares++;
                $display("FAIL wr_resp addr=%h: BVALID/BRESP=%b/%b, required 1/%b", a, S_AXI_BVALID, S_AXI_BRESP, exp);
            end
            @(posedge S_AXI_ACLK); #1;
        end
    endtask

    task automatic axi_read(input logic [6:0] a);
        int n = 0;
        logic [31:0] exp;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
        rq.push_back(model[a[6:2]]);
        do begin @(posedge S_AXI_ACLK); #1; n++; end while (!S_AXI_ARREADY && n < 20);
        vectors++;
        exp = rq.pop_front();
        if (!S_AXI_ARREADY) begin
            miscompares++;
            $display("FAIL rd_timeout addr=%h: ARREADY=%b after %0d cycles, required 1", a, S_AXI_ARREADY, n);
            S_AXI_ARVALID = 0;
        end else begin
            @(posedge S_AXI_ACLK); #1;
            S_AXI_ARVALID = 0;
            if ({S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA} !== {1'b1, 2'b00, exp}) begin
                miscompares++;
                $display("FAIL rd_data addr=%h: RVALID/RRESP/RDATA=%b/%b/%h, required 1/00/%h",
                         a, S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA, exp);
            end
            @(posedge S_AXI_ACLK); #1;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) model[i] = 0;
        @(posedge S_AXI_ACLK); #1;
        vectors++;
        if (outs() !== 44'd0) begin miscompares++; $display("FAIL reset_held: outputs=%h, required 0", outs()); end
        S_AXI_ARESET = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge S_AXI_ACLK); #1;
            vectors++;
            if (outs() !== 44'd0) begin miscompares++; $display("FAIL reset_idle cyc%0d: outputs=%h, required 0", i, outs()); end
        end
    endtask

    // Write held un-acknowledged while reads to the same address stream in.
    task automatic test_write_stall();
        int aw_pulses = 0, bv = 0;
        bit got_r = 0;
        logic [31:0] exp;
        bq.push_back(2'b00);
        rq.push_back(model[16]);
        S_AXI_AWADDR = 7'h40; S_AXI_WDATA = 32'h8000_0000; S_AXI_WSTRB = 4'b1000;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 0;
        S_AXI_ARADDR = 7'h40; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
        for (int i = 0; i < 8; i++) begin
            @(posedge S_AXI_ACLK); #1;
            if (S_AXI_AWREADY) aw_pulses++;
            if (S_AXI_BVALID) bv++;
            if (S_AXI_RVALID && !got_r) begin
                got_r = 1; S_AXI_ARVALID = 0;
                exp = rq.pop_front();
                vectors++;
                if (S_AXI_RDATA !== exp) begin miscompares++; $display("FAIL stall_old_rdata: RDATA=%h, required %h", S_AXI_RDATA, exp); end
            end
        end
        model[16] = merge(model[16], 32'h8000_0000, 4'b1000);
        vectors++;
        if (!got_r) begin miscompares++; $display("FAIL stall_rvalid: RVALID never seen, required a pulse"); void'(rq.pop_front()); end
        vectors++;
        if (aw_pulses !== 1) begin miscompares++; $display("FAIL stall_aw_pulses: %0d pulses, required 1", aw_pulses); end
        vectors++;
        if (bv !== 7) begin miscompares++; $display("FAIL stall_bvalid_hold: BVALID high %0d cycles, required 7", bv); end
        exp = {30'd0, bq.pop_front()};
        vectors++;
        if ({S_AXI_BVALID, S_AXI_BRESP} !== {1'b1, exp[1:0]}) begin
            miscompares++; $display("FAIL stall_bresp: BVALID/BRESP=%b/%b, required 1/%b", S_AXI_BVALID, S_AXI_BRESP, exp[1:0]);
        end
    endtask

    task automatic test_bready_release();
        logic [1:0] exp;
        S_AXI_BREADY = 1;
        bq.push_back(2'b00);
        @(posedge S_AXI_ACLK); #1;
        vectors++;
        if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b011) begin
            miscompares++; $display("FAIL release_drop: BVALID/AWREADY/WREADY=%b%b%b, required 011", S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY);
        end
        @(posedge S_AXI_ACLK); #1;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        exp = bq.pop_front();
        vectors++;
        if ({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY} !== {1'b1, exp, 1'b0}) begin
            miscompares++; $display("FAIL release_second_wr: BVALID/BRESP/AWREADY=%b/%b/%b, required 1/%b/0", S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, exp);
        end
        @(posedge S_AXI_ACLK); #1;
        vectors++;
        if (S_AXI_BVALID !== 1'b0) begin miscompares++; $display("FAIL release_bclear: BVALID=%b, required 0", S_AXI_BVALID); end
        axi_read(7'h40);
    endtask

    task automatic test_strobe();
        axi_write(7'h04, 32'h1122_3344, 4'hF);
        axi_write(7'h05, 32'hA5A5_A5A5, 4'b0101);
        axi_read(7'h07);
    endtask

    task automatic test_read_stall();
        int n = 0;
        logic [31:0] e0, e1;
        axi_write(7'h7C, 32'hDEAD_BEEF, 4'hF);
        rq.push_back(model[31]);
        rq.push_back(model[1]);
        S_AXI_ARADDR = 7'h7C; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
        do begin @(posedge S_AXI_ACLK); #1; n++; end while (!S_AXI_ARREADY && n < 20);
        @(posedge S_AXI_ACLK); #1;
        S_AXI_ARADDR = 7'h04;
        e0 = rq.pop_front();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RDATA} !== {2'b10, e0}) begin
                miscompares++; $display("FAIL rstall_hold cyc%0d: RVALID/ARREADY/RDATA=%b/%b/%h, required 1/0/%h", i, S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RDATA, e0);
            end
            @(posedge S_AXI_ACLK); #1;
        end
        S_AXI_RREADY = 1;
        @(posedge S_AXI_ACLK); #1;
        vectors++;
        if ({S_AXI_RVALID, S_AXI_ARREADY} !== 2'b01) begin
            miscompares++; $display("FAIL rstall_accept: RVALID/ARREADY=%b/%b, required 0/1", S_AXI_RVALID, S_AXI_ARREADY);
        end
        @(posedge S_AXI_ACLK); #1;
        S_AXI_ARVALID = 0;
        e1 = rq.pop_front();
        vectors++;
        if ({S_AXI_RVALID, S_AXI_RDATA} !== {1'b1, e1}) begin
            miscompares++; $display("FAIL rstall_next: RVALID/RDATA=%b/%h, required 1/%h", S_AXI_RVALID, S_AXI_RDATA, e1);
        end
        @(posedge S_AXI_ACLK); #1;
    endtask

    task automatic test_back_to_back();
        logic [6:0] addrs [6];
        for (int i = 0; i < 6; i++) begin
            addrs[i] = 7'($urandom_range(0, 127));
            axi_write(addrs[i], $urandom, 4'($urandom_range(1, 15)));
        end
        for (int i = 0; i < 6; i++) axi_read(addrs[i]);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        S_AXI_AWADDR = 7'h08; S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 0;
        do begin @(posedge S_AXI_ACLK); #1; n++; end while (!S_AXI_AWREADY && n < 20);
        @(posedge S_AXI_ACLK); #1;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        vectors++;
        if (S_AXI_BVALID !== 1'b1) begin miscompares++; $display("FAIL midrst_pre: BVALID=%b, required 1", S_AXI_BVALID); end
        #2 S_AXI_ARESET = 1;
        #1;
        vectors++;
        if (outs() !== 44'd0) begin miscompares++; $display("FAIL midrst_async: outputs=%h, required 0", outs()); end
        @(posedge S_AXI_ACLK); #1;
        S_AXI_ARESET = 0; S_AXI_BREADY = 1;
        for (int i = 0; i < 32; i++) model[i] = 0;
        axi_read(7'h08);
        axi_read(7'h40);
    endtask

    initial begin
        test_reset();
        test_write_stall();
        test_bready_release();
        test_strobe();
        test_read_stall();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axil_demo_regs.md
Name: axil_demo_regs

Overview:
- AXI4-Lite slave exposing 32 read/write 32-bit registers (slv_reg0..slv_reg31) in a 128-byte address window.
- Peripheral-side demo/config register bank sitting behind an AXI-Lite interconnect.
- Must be fully AXI-Lite protocol compliant:
  - responses held until accepted;
  - no new transaction accepted while its response channel is stalled.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 7, byte address width; register index = addr[6:2]

Ports:
- S_AXI_ACLK  in  1  clock, all logic on rising edge
- S_AXI_ARESET  in  1  asynchronous active-high reset
- S_AXI_AWADDR  in  7  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response, always 2'b00 (OKAY)
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_ARADDR  in  7  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response, always 2'b00 (OKAY)
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready

Behaviour:

Reset:
- While S_AXI_ARESET=1, all outputs and all registers are 0, asynchronously.
- Outputs: AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA, BRESP, RRESP.
- Registers: slv_reg0..31.

Write path (all outputs registered):
- AWREADY and WREADY are asserted together for exactly one cycle. They rise on an edge where all of these hold:
  - AWVALID=1, WVALID=1, AWREADY=0;
  - (BVALID=0 or BREADY=1).
- Handshake edge = edge where AWREADY&AWVALID&WREADY&WVALID are all 1. On that edge:
  - register addr[6:2] is updated byte-wise: byte i takes WDATA[8i+7:8i] iff WSTRB[i]=1, other bytes unchanged;
  - BVALID is set to 1.
- BVALID stays 1, with BRESP unchanged, until an edge with BREADY=1; it then clears unless a new handshake on that same edge sets it again.
- While BVALID=1 and BREADY=0, AWREADY/WREADY must not be raised, so at most one write is outstanding.
- Address lower bits [1:0] are ignored.
- Max throughput: one write per 2 cycles.

Read path:
- ARREADY is asserted for one cycle. It rises on an edge where all of these hold:
  - ARVALID=1, ARREADY=0;
  - (RVALID=0 or RREADY=1).
- On the AR handshake edge:
  - RDATA is loaded with register araddr[6:2], sampled before any write landing on the same edge, i.e. it returns the old value;
  - RVALID is set to 1.
- RVALID and RDATA stay stable until an edge with RREADY=1.
- No new AR is accepted while RVALID=1 and RREADY=0.

Concurrency and mid-operation reset:
- Read and write channels are independent and may handshake on the same edge.
- Reset asserted mid-transaction aborts everything: outputs return to 0 and the register contents are lost.

Decomposition:
- Shared package: AXI response codes RESP_OKAY=2'b00, SLVERR=2'b10; NUM_REGS=32; ADDR_LSB=2.
- One sub-module is natural: axil_demo_regfile, holding the 32x32 register array with a byte-strobed write port and a combinational read mux.
- The top module holds the AXI handshake logic.

Test Plan:
1. Reset held 1 cycle, then released with all VALIDs low → every output stays 0 for 3+ cycles.
2. Write 0x80000000, WSTRB=4'b1000, to addr 0x40 with BREADY=0; AW/W/AR all asserted continuously to 0x40 with RREADY=1:
   - exactly one AWREADY/WREADY pulse;
   - BVALID=1 and held for 4+ cycles, with no further AWREADY pulses;
   - RVALID pulses with RDATA=0 (old value);
   - slv_reg16=0x80000000.
3. Raise BREADY one cycle after scenario 2 → BVALID drops next edge; the next AW/W pair is accepted 1 cycle later.
4. Write 0xA5A5A5A5 to 0x04 with WSTRB=4'b0101 over a reg previously 0x11223344, then read 0x04 → RDATA=0x11A533A5, RRESP=0.
5. Read 0x7C with RREADY=0 for 3 cycles → RVALID and RDATA stable; ARREADY not reasserted even with ARVALID high; accepted on the RREADY=1 edge.
6. Reset asserted while BVALID=1 → BVALID=0 immediately (asynchronously); a subsequent read of the previously written reg returns 0.
